mem_arb: RTL and testbench
==========================

# mem_arb

Unified-memory port arbiter for the diad pipeline. It shares one synchronous memory port between the instruction-fetch stage (IF) and the memory-access stage (MA). It runs each access as a multi-cycle transaction with configurable wait states and returns per-requester acknowledge and read data. It also produces the stall signals the pipeline uses to freeze IF or MA while that stage's request is pending.

## Interface
- ADDR_WIDTH, 24, address width of both requesters and the memory port
- DATA_WIDTH, 24, data word width
- WAIT_STATES, 0, extra memory latency cycles beyond one; range 0..15

- iw_clk  in  1  clock, all state updates on rising edge
- iw_rst  in  1  reset, synchronous, active-high
- iw_if_req  in  1  fetch request; held with stable address until ack or flush
- iw_if_addr  in  ADDR_WIDTH  fetch address
- iw_if_flush  in  1  branch taken; discards any outstanding fetch
- ow_if_ack  out  1  one-cycle pulse: fetch complete, ow_if_rdata valid
- ow_if_rdata  out  DATA_WIDTH  fetched word
- ow_if_stall  out  1  iw_if_req & ~ow_if_ack
- iw_ma_req  in  1  data request; held stable until ack
- iw_ma_we  in  1  1 = write, 0 = read
- iw_ma_addr  in  ADDR_WIDTH  data address
- iw_ma_wdata  in  DATA_WIDTH  write data
- ow_ma_ack  out  1  one-cycle pulse: data access complete
- ow_ma_rdata  out  DATA_WIDTH  read data; valid only with ack and we=0
- ow_ma_stall  out  1  iw_ma_req & ~ow_ma_ack
- ow_mem_req  out  1  one-cycle memory strobe
- ow_mem_we  out  1  memory write enable, qualified by ow_mem_req
- ow_mem_addr  out  ADDR_WIDTH  memory address
- ow_mem_wdata  out  DATA_WIDTH  memory write data
- iw_mem_rdata  in  DATA_WIDTH  memory read data, valid WAIT_STATES+1 cycles after strobe
- ow_busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A grant register records the grantee (IF or MA). A 4-bit down-counter counts wait states.
- Arbitration in IDLE:
  - MA has priority over IF.
  - Winner's address, we (IF forces 0) and wdata are latched into the ow_mem_* registers.
  - Counter loads WAIT_STATES; next state is ISSUE.
  - With no request, the FSM stays in IDLE.
- ISSUE: ow_mem_req=1 for exactly this cycle. Next state is WAIT if the counter is nonzero, else RESP.
- WAIT: counter decrements each cycle; at 1, next state is RESP.
- RESP:
  - The grantee's ack is asserted. Its rdata equals iw_mem_rdata combinationally.
  - Back-to-back re-arbitration considers only the non-grantee's request (the grantee's req is still high this cycle).
  - If the non-grantee is requesting, it is latched and the FSM goes directly to ISSUE; otherwise it goes to IDLE.
  - Consequence: a waiting requester is serviced after at most one access of the other requester, so there is no starvation.
- Flush:
  - Fetch in flight (grantee IF in ISSUE/WAIT/RESP) or iw_if_flush high in the RESP cycle: the memory access completes normally, but ow_if_ack is suppressed.
  - A sticky flush flag covers the in-flight case; it clears on leaving RESP.
  - Flush in IDLE with iw_if_req high: IF is not granted that cycle.
  - Flush never affects MA accesses.
- ow_mem_addr/we/wdata hold their last latched values between accesses. Only ow_mem_req qualifies them.

## Timing
- Reset state: FSM IDLE, grant=IF, counter 0, flush flag 0.
- Reset values:
  - ow_mem_req, ow_mem_we, ow_if_ack, ow_ma_ack, ow_busy = 0.
  - ow_mem_addr, ow_mem_wdata = 0.
  - ow_if_stall, ow_ma_stall follow their request inputs.
- Latency: request seen in IDLE at cycle t gives strobe at t+1 and ack at t+2+WAIT_STATES.
- Throughput: back-to-back alternating accesses occupy WAIT_STATES+2 cycles each. A single repeated requester occupies WAIT_STATES+3 cycles (passes through IDLE).
- Simultaneous IF and MA requests in IDLE: MA granted; IF acked WAIT_STATES+2 cycles after MA's ack.
- Reset mid-transaction: abandons immediately, no ack is issued, ow_mem_req deasserts the next edge. Memory side effects of an already-issued write stand.
- Requester dropping req before ack is illegal, except IF under flush.

## Test plan
- WAIT_STATES=0, IF req addr 0x000010 at cycle 2, memory returns 0xABCDEF → ow_mem_req at 3 with addr 0x000010, ow_if_ack and rdata 0xABCDEF at 4, ow_if_stall high cycles 2–3.
- WAIT_STATES=2, MA write addr 0x20 data 0x123456 and IF read 0x04 both raised at cycle 2 → MA strobe at 3 (we=1, wdata 0x123456), MA ack at 6, IF strobe at 7 (we=0), IF ack at 10.
- WAIT_STATES=1, MA req held continuously with IF also requesting → grants alternate MA, IF, MA; neither waits more than one foreign access.
- WAIT_STATES=3, IF req at 2, iw_if_flush pulsed at 4 → strobe at 3, no ow_if_ack at 7, FSM IDLE at 8; new IF req then acked normally.
- iw_rst asserted during WAIT of an MA read → next edge: IDLE, ow_mem_req=0, no ack; after release, a fresh request completes with nominal latency.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: shares one wait-stated memory port between the fetch (IF) and data (MA) requesters, MA first.
module mem_arb #(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 24,
    parameter int WAIT_STATES = 0
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_if_req,
    input  logic [ADDR_WIDTH-1:0] iw_if_addr,
    input  logic                  iw_if_flush,
    output logic                  ow_if_ack,
    output logic [DATA_WIDTH-1:0] ow_if_rdata,
    output logic                  ow_if_stall,
    input  logic                  iw_ma_req,
    input  logic                  iw_ma_we,
    input  logic [ADDR_WIDTH-1:0] iw_ma_addr,
    input  logic [DATA_WIDTH-1:0] iw_ma_wdata,
    output logic                  ow_ma_ack,
    output logic [DATA_WIDTH-1:0] ow_ma_rdata,
    output logic                  ow_ma_stall,
    output logic                  ow_mem_req,
    output logic                  ow_mem_we,
    output logic [ADDR_WIDTH-1:0] ow_mem_addr,
    output logic [DATA_WIDTH-1:0] ow_mem_wdata,
    input  logic [DATA_WIDTH-1:0] iw_mem_rdata,
    output logic                  ow_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  flush_q, flush_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ma_win, if_win, win;
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    // In RESP only the requester that was not just served may win, which gives strict alternation.
    always_comb begin
        ma_win  = iw_ma_req & ((state_q == IDLE) | ((state_q == RESP) & ~grant_q));
        if_win  = iw_if_req & ~iw_if_flush & ~ma_win & ((state_q == IDLE) | ((state_q == RESP) & grant_q));
        win     = ma_win | if_win;
        state_d = state_q;
        grant_d = win ? ma_win : grant_q;
        cnt_d   = win ? WS : cnt_q;
        addr_d  = ma_win ? iw_ma_addr : (if_win ? iw_if_addr : addr_q);
        we_d    = win ? (ma_win & iw_ma_we) : we_q;
        wdata_d = ma_win ? iw_ma_wdata : wdata_q;
        flush_d = (state_q != RESP) & (flush_q | ((state_q != IDLE) & ~grant_q & iw_if_flush));
        case (state_q)
            IDLE:    state_d = win ? ISSUE : IDLE;
            ISSUE:   state_d = (cnt_q != 4'd0) ? WAIT : RESP;
            WAIT: begin
                state_d = (cnt_q == 4'd1) ? RESP : WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = win ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign ow_mem_req   = state_q == ISSUE;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_busy      = state_q != IDLE;
    assign ow_if_ack    = (state_q == RESP) & ~grant_q & ~flush_q & ~iw_if_flush;
    assign ow_ma_ack    = (state_q == RESP) & grant_q;
    assign ow_if_rdata  = iw_mem_rdata;
    assign ow_ma_rdata  = iw_mem_rdata;
    assign ow_if_stall  = iw_if_req & ~ow_if_ack;
    assign ow_ma_stall  = iw_ma_req & ~ow_ma_ack;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: four arbiters (WAIT_STATES 0..3) share stimulus; each task observes the one selected by d.
module tb_mem_arb;
    logic        iw_clk, iw_rst, if_req, if_flush, ma_req, ma_we;
    logic [23:0] if_addr, ma_addr, ma_wdata, mem_rdata;
    logic        if_ack_o [4], if_stall_o [4], ma_ack_o [4], ma_stall_o [4];
    logic        mem_req_o [4], mem_we_o [4], busy_o [4];
    logic [23:0] if_rdata_o [4], ma_rdata_o [4], mem_addr_o [4], mem_wdata_o [4];
    logic [23:0] emu [256], ref_mem [256];
    logic [23:0] rd_val;
    int          vec = 0, errs = 0, cyc = 0, d = 0, rd_due = -10;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_arb #(.ADDR_WIDTH(24), .DATA_WIDTH(24), .WAIT_STATES(g)) u_dut (
            .iw_clk(iw_clk), .iw_rst(iw_rst),
            .iw_if_req(if_req), .iw_if_addr(if_addr), .iw_if_flush(if_flush),
            .ow_if_ack(if_ack_o[g]), .ow_if_rdata(if_rdata_o[g]), .ow_if_stall(if_stall_o[g]),
            .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
            .ow_ma_ack(ma_ack_o[g]), .ow_ma_rdata(ma_rdata_o[g]), .ow_ma_stall(ma_stall_o[g]),
            .ow_mem_req(mem_req_o[g]), .ow_mem_we(mem_we_o[g]), .ow_mem_addr(mem_addr_o[g]),
            .ow_mem_wdata(mem_wdata_o[g]), .iw_mem_rdata(mem_rdata), .ow_busy(busy_o[g])
        );
    end

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;
    always @(posedge iw_clk) cyc <= cyc + 1;

    // Memory of the selected DUT: read data is valid only in the cycle WAIT_STATES+1 after the strobe.
    always begin
        @(posedge iw_clk);
        #2;
        mem_rdata = (cyc == rd_due) ? rd_val : 24'($urandom);
        if (mem_req_o[d]) begin
            if (mem_we_o[d]) emu[mem_addr_o[d][7:0]] = mem_wdata_o[d];
            else begin
                rd_val = emu[mem_addr_o[d][7:0]];
                rd_due = cyc + d + 1;
            end
        end
    end

    task automatic do_reset();
        iw_rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; ma_req = 1'b0; ma_we = 1'b0;
        if_addr = '0; ma_addr = '0; ma_wdata = '0;
        repeat (2) @(posedge iw_clk);
        #1 iw_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        do_reset();
        iw_rst = 1'b1; if_req = 1'b1;
        repeat (2) @(posedge iw_clk);
        @(negedge iw_clk);
        for (int g = 0; g < 4; g++) begin
            got = {mem_req_o[g], mem_we_o[g], if_ack_o[g], ma_ack_o[g], busy_o[g], if_stall_o[g], ma_stall_o[g]};
            vec++;
            if (got !== 7'b0000010) begin errs++; $display("FAIL reset_ctl dut%0d got %b exp 0000010", g, got); end
            vec++;
            if ({mem_addr_o[g], mem_wdata_o[g]} !== 48'h0) begin
                errs++; $display("FAIL reset_regs dut%0d got %h/%h exp 0/0", g, mem_addr_o[g], mem_wdata_o[g]);
            end
        end
        if_req = 1'b0; ma_req = 1'b1;
        @(negedge iw_clk);
        vec++;
        if ({if_stall_o[0], ma_stall_o[0]} !== 2'b01) begin
            errs++; $display("FAIL reset_stall got %b exp 01", {if_stall_o[0], ma_stall_o[0]});
        end
        iw_rst = 1'b0; ma_req = 1'b0;
    endtask

    task automatic test_basic();
        logic [2:0] e, got;
        d = 0; do_reset(); emu[8'h10] = 24'hABCDEF;
        for (int r = 0; r < 5; r++) begin
            @(posedge iw_clk); #1;
            if (r == 0) begin if_req = 1'b1; if_addr = 24'h000010; end
            if (r == 3) if_req = 1'b0;
            @(negedge iw_clk);
            e = {r == 1, r == 2, r < 2};
            got = {mem_req_o[0], if_ack_o[0], if_stall_o[0]};
            vec++;
            if (got !== e) begin errs++; $display("FAIL basic_ctl r=%0d got %b exp %b", r, got, e); end
            if (r == 1) begin
                vec++;
                if ({mem_addr_o[0], mem_we_o[0]} !== {24'h000010, 1'b0}) begin
                    errs++; $display("FAIL basic_strobe got %h/%b exp 000010/0", mem_addr_o[0], mem_we_o[0]);
                end
            end
            if (r == 2) begin
                vec++;
                if (if_rdata_o[0] !== 24'hABCDEF) begin errs++; $display("FAIL basic_rdata got %h exp abcdef", if_rdata_o[0]); end
            end
        end
    endtask

    task automatic test_priority();
        logic [5:0] e, got;
        d = 2; do_reset(); emu[8'h04] = 24'h0BEEF0;
        for (int r = 0; r < 11; r++) begin
            @(posedge iw_clk); #1;
            if (r == 0) begin
                ma_req = 1'b1; ma_we = 1'b1; ma_addr = 24'h20; ma_wdata = 24'h123456;
                if_req = 1'b1; if_addr = 24'h04;
            end
            if (r == 5) ma_req = 1'b0;
            if (r == 9) if_req = 1'b0;
            @(negedge iw_clk);
            e = {r == 1 || r == 5, r == 4, r == 8, r >= 1 && r <= 8, r <= 7, r <= 3};
            got = {mem_req_o[2], ma_ack_o[2], if_ack_o[2], busy_o[2], if_stall_o[2], ma_stall_o[2]};
            vec++;
            if (got !== e) begin errs++; $display("FAIL prio_ctl r=%0d got %b exp %b", r, got, e); end
            if (r == 1) begin
                vec++;
                if ({mem_addr_o[2], mem_we_o[2], mem_wdata_o[2]} !== {24'h20, 1'b1, 24'h123456}) begin
                    errs++; $display("FAIL prio_ma_strobe got %h/%b/%h exp 000020/1/123456", mem_addr_o[2], mem_we_o[2], mem_wdata_o[2]);
                end
            end
            if (r == 5) begin
                vec++;
                if ({mem_addr_o[2], mem_we_o[2]} !== {24'h04, 1'b0}) begin
                    errs++; $display("FAIL prio_if_strobe got %h/%b exp 000004/0", mem_addr_o[2], mem_we_o[2]);
                end
            end
            if (r == 8) begin
                vec++;
                if (if_rdata_o[2] !== 24'h0BEEF0) begin errs++; $display("FAIL prio_rdata got %h exp 0beef0", if_rdata_o[2]); end
            end
        end
    endtask

    task automatic test_alternate();
        logic [2:0] e, got;
        d = 1; do_reset(); emu[8'h30] = 24'h303030; emu[8'h40] = 24'h404040;
        for (int r = 0; r < 13; r++) begin
            @(posedge iw_clk); #1;
            if (r == 0) begin
                ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h30;
                if_req = 1'b1; if_addr = 24'h40;
            end
            @(negedge iw_clk);
            e = {r % 3 == 1, r % 6 == 3, r % 6 == 0 && r > 0};
            got = {mem_req_o[1], ma_ack_o[1], if_ack_o[1]};
            vec++;
            if (got !== e) begin errs++; $display("FAIL alt_ctl r=%0d got %b exp %b", r, got, e); end
            if (r % 3 == 1) begin
                vec++;
                if (mem_addr_o[1] !== ((r % 6 == 1) ? 24'h30 : 24'h40)) begin
                    errs++; $display("FAIL alt_addr r=%0d got %h", r, mem_addr_o[1]);
                end
            end
            if (r % 6 == 3) begin
                vec++;
                if (ma_rdata_o[1] !== 24'h303030) begin errs++; $display("FAIL alt_rdata r=%0d got %h exp 303030", r, ma_rdata_o[1]); end
            end
        end
        if_req = 1'b0; ma_req = 1'b0;
    endtask

    task automatic test_flush();
        logic [2:0] e, got;
        d = 3; do_reset(); emu[8'h60] = 24'h600D01;
        for (int r = 0; r < 16; r++) begin
            @(posedge iw_clk); #1;
            if (r == 0) begin if_req = 1'b1; if_addr = 24'h50; end
            if (r == 2) begin if_flush = 1'b1; if_req = 1'b0; end
            if (r == 3) if_flush = 1'b0;
            if (r == 7) begin if_req = 1'b1; if_addr = 24'h60; end
            if (r == 13) if_req = 1'b0;
            if (r == 14) begin if_req = 1'b1; if_flush = 1'b1; end
            if (r == 15) begin if_req = 1'b0; if_flush = 1'b0; end
            @(negedge iw_clk);
            e = {r == 1 || r == 8, r == 12, (r >= 1 && r <= 5) || (r >= 8 && r <= 12)};
            got = {mem_req_o[3], if_ack_o[3], busy_o[3]};
            vec++;
            if (got !== e) begin errs++; $display("FAIL flush_ctl r=%0d got %b exp %b", r, got, e); end
            if (r == 12) begin
                vec++;
                if (if_rdata_o[3] !== 24'h600D01) begin errs++; $display("FAIL flush_rdata got %h exp 600d01", if_rdata_o[3]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e, got;
        d = 2; do_reset(); emu[8'h70] = 24'h707070; emu[8'h71] = 24'h717171;
        for (int r = 0; r < 11; r++) begin
            @(posedge iw_clk); #1;
            if (r == 0) begin ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h70; end
            if (r == 2) begin iw_rst = 1'b1; ma_req = 1'b0; end
            if (r == 3) iw_rst = 1'b0;
            if (r == 5) begin ma_req = 1'b1; ma_addr = 24'h71; end
            if (r == 10) ma_req = 1'b0;
            @(negedge iw_clk);
            e = {r == 1 || r == 6, r == 9, r == 1 || r == 2 || (r >= 6 && r <= 9)};
            got = {mem_req_o[2], ma_ack_o[2], busy_o[2]};
            vec++;
            if (got !== e) begin errs++; $display("FAIL rstmid_ctl r=%0d got %b exp %b", r, got, e); end
            if (r == 9) begin
                vec++;
                if (ma_rdata_o[2] !== 24'h717171) begin errs++; $display("FAIL rstmid_rdata got %h exp 717171", ma_rdata_o[2]); end
            end
        end
    endtask

    // Reference: a transaction granted at cycle gc strobes at gc+1 and acks at gc+2+W; at the ack
    // only the other requester may take over, otherwise the port is free again from the next cycle.
    task automatic test_random(input int dd);
        bit act, who, e_strb, e_ack, pif, pma, gr, twe;
        int gc;
        logic [23:0] ta, twd, e_rd, got_rd;
        logic [5:0] ev, gv;
        d = dd; do_reset();
        for (int i = 0; i < 256; i++) begin emu[i] = 24'($urandom); ref_mem[i] = emu[i]; end
        act = 0; who = 0; pif = 0; pma = 0; gc = 0; ta = '0; twd = '0; twe = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge iw_clk); #1;
            if (pif || !if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1'b1; if_addr = 24'($urandom); end
                else if_req = 1'b0;
            end
            if (pma || !ma_req) begin
                if ($urandom_range(2) == 0) begin
                    ma_req = 1'b1; ma_we = 1'($urandom); ma_addr = 24'($urandom); ma_wdata = 24'($urandom);
                end else ma_req = 1'b0;
            end
            e_strb = act && c == gc + 1;
            e_ack  = act && c == gc + 2 + dd;
            ev = {e_strb, e_ack && !who, e_ack && who, act, if_req && !(e_ack && !who), ma_req && !(e_ack && who)};
            e_rd = ref_mem[ta[7:0]];
            @(negedge iw_clk);
            gv = {mem_req_o[dd], if_ack_o[dd], ma_ack_o[dd], busy_o[dd], if_stall_o[dd], ma_stall_o[dd]};
            vec++;
            if (gv !== ev) begin errs++; $display("FAIL rnd_ctl w=%0d c=%0d got %b exp %b", dd, c, gv, ev); end
            if (e_strb) begin
                vec++;
                if ({mem_addr_o[dd], mem_we_o[dd]} !== {ta, twe} || (twe && mem_wdata_o[dd] !== twd)) begin
                    errs++; $display("FAIL rnd_strobe w=%0d c=%0d got %h/%b/%h exp %h/%b/%h", dd, c,
                                     mem_addr_o[dd], mem_we_o[dd], mem_wdata_o[dd], ta, twe, twd);
                end
            end
            if (e_ack && !twe) begin
                got_rd = who ? ma_rdata_o[dd] : if_rdata_o[dd];
                vec++;
                if (got_rd !== e_rd) begin errs++; $display("FAIL rnd_rdata w=%0d c=%0d got %h exp %h", dd, c, got_rd, e_rd); end
            end
            pif = e_ack && !who;
            pma = e_ack && who;
            gr = 0;
            if (e_ack) begin
                if (twe) ref_mem[ta[7:0]] = twd;
                act = 0;
                if (who ? if_req : ma_req) begin gr = 1; who = !who; end
            end else if (!act && (ma_req || if_req)) begin
                gr = 1; who = ma_req;
            end
            if (gr) begin
                act = 1; gc = c;
                ta  = who ? ma_addr : if_addr;
                twe = who && ma_we;
                twd = ma_wdata;
            end
        end
        if_req = 1'b0; ma_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_alternate();
        test_flush();
        test_reset_mid();
        for (int w = 0; w < 4; w++) test_random(w);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
